// File: rtl/clk_tick_gen_pkg.sv
// Shared definitions for the multi-channel clock-enable generator:
// mode codes, burst FSM encoding and the board's default divisors.
package clk_tick_pkg;

   localparam logic [1:0] MODE_RUN   = 2'd0;
   localparam logic [1:0] MODE_HALT  = 2'd1;
   localparam logic [1:0] MODE_STEP  = 2'd2;
   localparam logic [1:0] MODE_BURST = 2'd3;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } burst_state_e;

   // 50 MHz board clock divided down to the classic SAP-1 rates
   localparam int unsigned DIV_1HZ   = 50_000_000;
   localparam int unsigned DIV_10HZ  = 5_000_000;
   localparam int unsigned DIV_100HZ = 500_000;
   localparam int unsigned DIV_1KHZ  = 50_000;

   localparam int BOARD_CNT_W = 26;
   localparam logic [4*BOARD_CNT_W-1:0] BOARD_DIVISORS = {
      26'(DIV_1KHZ), 26'(DIV_100HZ), 26'(DIV_10HZ), 26'(DIV_1HZ)
   };

   // Width of a channel-select field; never narrower than one bit
   function automatic int sel_width(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/clk_tick_gen_if.sv
// Control/status bundle between the board top and clk_tick_gen.
// There is no valid/ready handshake on this bus: every input is a level
// sampled on each clock edge, o_tick and o_cpu_ce are one-cycle strobes,
// o_sq and o_busy are levels, and dbg_state mirrors the burst FSM register.
interface clk_tick_gen_if #(
   parameter int N_CH    = 4,
   parameter int BURST_W = 8
);
   import clk_tick_pkg::*;

   localparam int SEL_W = sel_width(N_CH);

   logic                i_en;
   logic [SEL_W-1:0]    i_sel;
   logic [1:0]          i_mode;
   logic                i_step_n;
   logic [BURST_W-1:0]  i_burst;
   logic [N_CH-1:0]     o_tick;
   logic [N_CH-1:0]     o_sq;
   logic                o_cpu_ce;
   logic                o_busy;
   burst_state_e        dbg_state;

   modport master (
      output i_en, i_sel, i_mode, i_step_n, i_burst,
      input  o_tick, o_sq, o_cpu_ce, o_busy, dbg_state
   );

   modport slave (
      input  i_en, i_sel, i_mode, i_step_n, i_burst,
      output o_tick, o_sq, o_cpu_ce, o_busy, dbg_state
   );

endinterface

// File: rtl/clk_tick_gen_button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// registered one-cycle press event on the debounced falling edge.
module button_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn_n,
   output logic o_press
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             lvl_q, lvl_d;
   logic             lvl_dly_q, lvl_dly_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Accept a new level only after DEB_CYCLES consecutive differing samples
   always_comb begin
      sync1_d   = i_btn_n;
      sync2_d   = sync1_q;
      lvl_d     = lvl_q;
      cnt_d     = '0;
      if (sync2_q != lvl_q) begin
         if (cnt_q == LAST) begin
            lvl_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      lvl_dly_d = lvl_q;
      press_d   = lvl_dly_q & ~lvl_q;
   end

   // Released (high) is the reset level of every stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         lvl_q     <= 1'b1;
         lvl_dly_q <= 1'b1;
         press_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         lvl_q     <= lvl_d;
         lvl_dly_q <= lvl_dly_d;
         press_q   <= press_d;
         cnt_q     <= cnt_d;
      end
   end

   assign o_press = press_q;

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel tick/square generator with a CPU clock-enable path
// (RUN / HALT / STEP / BURST) fed by a debounced step button.
module clk_tick_gen
   import clk_tick_pkg::*;
#(
   parameter int                     N_CH       = 4,
   parameter int                     CNT_W      = BOARD_CNT_W,
   parameter logic [N_CH*CNT_W-1:0]  DIVISORS   = BOARD_DIVISORS,
   parameter int                     DEB_CYCLES = 1_000_000,
   parameter int                     BURST_W    = 8
) (
   input  logic          CLOCK_50MHz,
   input  logic          RESET,
   clk_tick_gen_if.slave bus
);

   localparam int SEL_W = sel_width(N_CH);

   logic [N_CH-1:0] tick_vec;
   logic [N_CH-1:0] sq_vec;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      localparam logic [CNT_W-1:0] DIV  = DIVISORS[k*CNT_W +: CNT_W];
      localparam logic [CNT_W-1:0] LAST = DIV - CNT_W'(1);
      // First count at which the square output is high: ceil(DIV/2)
      localparam logic [CNT_W:0]   HALF = ({1'b0, DIV} + (CNT_W+1)'(1)) >> 1;

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             tick_q, tick_d;
      logic             sq_q, sq_d;

      // Free-running 0..DIV-1 counter; a zero divisor parks the channel
      always_comb begin
         cnt_d  = cnt_q;
         tick_d = 1'b0;
         sq_d   = sq_q;
         if ((DIV != '0) && bus.i_en) begin
            tick_d = (cnt_q == LAST);
            cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
            sq_d   = ({1'b0, cnt_d} >= HALF);
         end
      end

      // Channel registers
      always_ff @(posedge CLOCK_50MHz or posedge RESET) begin
         if (RESET) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
         end
      end

      assign tick_vec[k] = tick_q;
      assign sq_vec[k]   = sq_q;
   end

   logic press_raw;
   logic press;

   button_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_step_deb (
      .clk     (CLOCK_50MHz),
      .rst     (RESET),
      .i_btn_n (bus.i_step_n),
      .o_press (press_raw)
   );

   // Presses seen while globally disabled are dropped, not queued
   assign press = press_raw & bus.i_en;

   logic [SEL_W-1:0] sel_idx;
   logic             sel_tick;

   // Out-of-range selects fall back to channel 0
   always_comb begin
      sel_idx  = (int'(bus.i_sel) < N_CH) ? bus.i_sel : '0;
      sel_tick = tick_vec[sel_idx];
   end

   burst_state_e       state_q, state_d;
   logic [BURST_W-1:0] rem_q, rem_d;
   logic               ce_q, ce_d;
   logic               busy_q, busy_d;

   // CPU enable source per mode; leaving BURST mode aborts a running burst
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      ce_d    = 1'b0;
      busy_d  = busy_q;
      if (bus.i_en) begin
         if (bus.i_mode != MODE_BURST) begin
            state_d = IDLE;
            rem_d   = '0;
            busy_d  = 1'b0;
         end
         case (bus.i_mode)
            MODE_RUN:  ce_d = sel_tick;
            MODE_STEP: ce_d = press;
            MODE_BURST: begin
               case (state_q)
                  IDLE: begin
                     if (press && (bus.i_burst != '0)) begin
                        state_d = BURST;
                        rem_d   = bus.i_burst;
                        busy_d  = 1'b1;
                     end
                  end
                  BURST: begin
                     if (sel_tick) begin
                        ce_d  = 1'b1;
                        rem_d = rem_q - BURST_W'(1);
                        if (rem_q == BURST_W'(1)) begin
                           state_d = IDLE;
                           busy_d  = 1'b0;
                        end
                     end
                  end
                  default: state_d = IDLE;
               endcase
            end
            default: ce_d = 1'b0;
         endcase
      end
   end

   // CPU enable / burst FSM registers
   always_ff @(posedge CLOCK_50MHz or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         rem_q   <= '0;
         ce_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         ce_q    <= ce_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.o_tick    = tick_vec;
   assign bus.o_sq      = sq_vec;
   assign bus.o_cpu_ce  = ce_q;
   assign bus.o_busy    = busy_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen: table of the first cycles after reset, then
// hand-written sequences for enable freeze, HALT/STEP, BURST and reset.
module tb_clk_tick_gen;
   import clk_tick_pkg::*;

   localparam int N_CH    = 4;
   localparam int CNT_W   = 8;
   localparam int BURST_W = 8;
   localparam int DEB     = 4;
   localparam logic [N_CH*CNT_W-1:0] DIVS = {8'd4, 8'd6, 8'd8, 8'd10};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   clk_tick_gen_if #(.N_CH(N_CH), .BURST_W(BURST_W)) bus ();

   clk_tick_gen #(
      .N_CH       (N_CH),
      .CNT_W      (CNT_W),
      .DIVISORS   (DIVS),
      .DEB_CYCLES (DEB),
      .BURST_W    (BURST_W)
   ) dut (
      .CLOCK_50MHz (clk),
      .RESET       (rst),
      .bus         (bus)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0] mode;
      logic [1:0] sel;
      logic [3:0] tick;  // {ch3, ch2, ch1, ch0}
      logic [3:0] sq;
      logic       ce;
   } vec_t;

   vec_t vecs [13];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test ----------------
   initial begin
      int pulses, last_ce, first_ce, first_busy, abort_c, k, cnt_t, cnt_bad;
      logic busy_seen;
      logic [3:0] sq_hold;

      // cycle n after reset release; divisors 10/8/6/4, RUN on channel 3
      vecs[0]  = '{MODE_RUN, 2'd3, 4'b0000, 4'b0000, 1'b0};
      vecs[1]  = '{MODE_RUN, 2'd3, 4'b0000, 4'b0000, 1'b0};
      vecs[2]  = '{MODE_RUN, 2'd3, 4'b0000, 4'b1000, 1'b0};
      vecs[3]  = '{MODE_RUN, 2'd3, 4'b0000, 4'b1100, 1'b0};
      vecs[4]  = '{MODE_RUN, 2'd3, 4'b1000, 4'b0110, 1'b0};
      vecs[5]  = '{MODE_RUN, 2'd3, 4'b0000, 4'b0111, 1'b1};
      vecs[6]  = '{MODE_RUN, 2'd3, 4'b0100, 4'b1011, 1'b0};
      vecs[7]  = '{MODE_RUN, 2'd3, 4'b0000, 4'b1011, 1'b0};
      vecs[8]  = '{MODE_RUN, 2'd3, 4'b1010, 4'b0001, 1'b0};
      vecs[9]  = '{MODE_RUN, 2'd3, 4'b0000, 4'b0101, 1'b1};
      vecs[10] = '{MODE_RUN, 2'd3, 4'b0001, 4'b1100, 1'b0};
      vecs[11] = '{MODE_RUN, 2'd3, 4'b0000, 4'b1100, 1'b0};
      vecs[12] = '{MODE_RUN, 2'd3, 4'b1100, 4'b0010, 1'b0};

      rst          = 1'b1;
      bus.i_en     = 1'b1;
      bus.i_mode   = MODE_RUN;
      bus.i_sel    = 2'd3;
      bus.i_step_n = 1'b1;
      bus.i_burst  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset busy", bus.o_busy, 1'b0);
      check("reset state", bus.dbg_state, IDLE);

      for (int n = 0; n < 13; n++) begin
         if (n > 0) @(negedge clk);
         check($sformatf("tick c%0d", n), bus.o_tick, vecs[n].tick);
         check($sformatf("sq c%0d", n), bus.o_sq, vecs[n].sq);
         check($sformatf("ce c%0d", n), bus.o_cpu_ce, vecs[n].ce);
         bus.i_mode = vecs[n].mode;
         bus.i_sel  = vecs[n].sel;
      end

      // RUN on channel 2, then freeze with i_en low for 7 cycles
      bus.i_sel = 2'd2;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.o_tick[2] && k < 20);
      check("run first tick2 found", bus.o_tick[2], 1'b1);
      @(negedge clk);
      check("run ce after tick2 a", bus.o_cpu_ce, 1'b1);
      k = 1;
      do begin @(negedge clk); k++; end while (!bus.o_tick[2] && k < 20);
      check("run tick2 period", k, 6);
      @(negedge clk);
      check("run ce after tick2 b", bus.o_cpu_ce, 1'b1);
      @(negedge clk);
      sq_hold  = bus.o_sq;
      bus.i_en = 1'b0;
      cnt_bad  = 0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (bus.o_tick != '0 || bus.o_cpu_ce) cnt_bad++;
      end
      check("en low no ticks", cnt_bad, 0);
      check("en low sq held", bus.o_sq, sq_hold);
      bus.i_en = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.o_tick[2] && k < 20);
      check("resume tick2 gap", k, 4);
      @(negedge clk);
      check("resume ce", bus.o_cpu_ce, 1'b1);

      // HALT for 100 cycles
      bus.i_mode = MODE_HALT;
      cnt_t = 0; pulses = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus.o_cpu_ce) pulses++;
         if (bus.o_tick[3]) cnt_t++;
      end
      check("halt ce count", pulses, 0);
      check("halt tick3 count", cnt_t, 25);

      // STEP with a 1-0-1 bounce before a 12-cycle press
      bus.i_mode = MODE_STEP;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         bus.i_step_n = (c == 0 || (c >= 2 && c < 14)) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (bus.o_cpu_ce) pulses++;
      end
      check("step pulses", pulses, 1);

      // BURST of 3 on channel 3
      bus.i_mode  = MODE_BURST;
      bus.i_sel   = 2'd3;
      bus.i_burst = 8'd3;
      pulses = 0; last_ce = -100; first_ce = -1; first_busy = -1;
      for (int c = 0; c < 40; c++) begin
         bus.i_step_n = (c < 8) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (bus.o_busy && first_busy < 0) first_busy = c;
         if (bus.o_cpu_ce) begin
            pulses++;
            if (pulses == 1) first_ce = c;
            else check($sformatf("burst3 spacing p%0d", pulses), c - last_ce, 4);
            check($sformatf("burst3 busy at p%0d", pulses), bus.o_busy, (pulses < 3));
            last_ce = c;
         end
      end
      check("burst3 pulses", pulses, 3);
      check("burst3 busy before ce", (first_busy >= 0 && first_busy < first_ce), 1'b1);
      check("burst3 busy end", bus.o_busy, 1'b0);

      // BURST of 3 on channel 0 with a second press mid-burst
      bus.i_sel = 2'd0;
      pulses = 0; last_ce = -100;
      for (int c = 0; c < 70; c++) begin
         bus.i_step_n = (c < 8 || (c >= 16 && c < 24)) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (bus.o_cpu_ce) begin
            pulses++;
            if (pulses > 1) check($sformatf("burst sel0 spacing p%0d", pulses), c - last_ce, 10);
            last_ce = c;
         end
      end
      check("burst second press ignored", pulses, 3);
      check("burst sel0 busy end", bus.o_busy, 1'b0);

      // BURST of 5 aborted by switching to HALT after 2 pulses
      bus.i_sel   = 2'd3;
      bus.i_burst = 8'd5;
      pulses = 0; abort_c = -1;
      for (int c = 0; c < 40; c++) begin
         bus.i_step_n = (c < 8) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (abort_c >= 0 && c == abort_c + 1) begin
            check("abort busy", bus.o_busy, 1'b0);
            check("abort state", bus.dbg_state, IDLE);
         end
         if (bus.o_cpu_ce) begin
            pulses++;
            if (pulses == 2) begin
               check("abort busy before", bus.o_busy, 1'b1);
               bus.i_mode = MODE_HALT;
               abort_c = c;
            end
         end
      end
      check("abort total pulses", pulses, 2);

      // i_burst = 0: press is ignored
      bus.i_mode  = MODE_BURST;
      bus.i_burst = 8'd0;
      pulses = 0; busy_seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         bus.i_step_n = (c < 8) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (bus.o_cpu_ce) pulses++;
         if (bus.o_busy) busy_seen = 1'b1;
      end
      check("zero burst pulses", pulses, 0);
      check("zero burst busy", busy_seen, 1'b0);

      // RESET in the middle of a burst
      bus.i_sel   = 2'd0;
      bus.i_burst = 8'd5;
      for (int c = 0; c < 14; c++) begin
         bus.i_step_n = (c < 8) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      check("pre-reset busy", bus.o_busy, 1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async reset tick", bus.o_tick, 4'b0000);
      check("async reset sq", bus.o_sq, 4'b0000);
      check("async reset ce", bus.o_cpu_ce, 1'b0);
      check("async reset busy", bus.o_busy, 1'b0);
      check("async reset state", bus.dbg_state, IDLE);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         check($sformatf("post-reset tick3 c%0d", n), bus.o_tick[3], (n == 4));
         check($sformatf("post-reset busy c%0d", n), bus.o_busy, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Parametrised multi-channel clock-enable generator for the SAP-1 board top. It replaces the fixed 1 Hz/10 Hz/100 Hz/1 kHz toggled-clock divider. All logic runs on CLOCK_50MHz and produces single-cycle tick enables plus 50 %-duty square outputs, one of each per channel. A CPU clock-enable path adds RUN, HALT, single STEP and N-pulse BURST modes, driven by a debounced push-button, so the CPU no longer needs a derived clock.

## Interface
- N_CH, 4, number of divider channels (1..16)
- CNT_W, 26, counter width per channel
- DIVISORS, {50_000, 500_000, 5_000_000, 50_000_000}, packed N_CH*CNT_W; channel k = bits [k*CNT_W +: CNT_W]; default ch0 = 1 Hz, ch1 = 10 Hz, ch2 = 100 Hz, ch3 = 1 kHz
- DEB_CYCLES, 1_000_000, debounce stability window (20 ms)
- BURST_W, 8, width of burst count

Ports:
- CLOCK_50MHz  in  1  system clock
- RESET  in  1  reset, asynchronous, active-high
- i_en  in  1  global enable; low freezes all counters and the FSM
- i_sel  in  $clog2(N_CH) (min 1)  channel feeding the CPU enable
- i_mode  in  2  0 RUN, 1 HALT, 2 STEP, 3 BURST
- i_step_n  in  1  raw push-button, active-low, asynchronous
- i_burst  in  BURST_W  pulse count for BURST mode
- o_tick  out  N_CH  one-cycle tick per channel
- o_sq  out  N_CH  square wave per channel
- o_cpu_ce  out  1  CPU clock enable, one-cycle pulses
- o_busy  out  1  burst in progress

## Operation
- Reset values: all outputs 0, counters 0, FSM IDLE, debouncer state "released".
- Channel k counter runs 0..DIV_k−1 and wraps.
  - o_tick[k] is registered and asserted for the one cycle after the counter equals DIV_k−1.
  - o_sq[k] is registered: low for ceil(DIV_k/2) counts, high for floor(DIV_k/2) counts.
  - DIV_k = 1: o_tick[k] is constant 1 after the first cycle, and o_sq[k] stays 0.
  - DIV_k = 0: channel is disabled; counter held at 0, outputs held at 0.
- i_en low: counters, o_sq and the FSM hold their values; o_tick and o_cpu_ce are forced to 0; the debouncer keeps running, but press events are discarded.
- Step input path: 2-FF synchroniser, then debouncer. The debouncer accepts a new level only after DEB_CYCLES consecutive equal samples. A press event is one cycle, generated on the debounced 1→0 transition.
- o_cpu_ce behaviour by mode:
  - RUN: registered copy of o_tick[i_sel].
  - HALT: 0.
  - STEP: exactly one pulse per press event, 1 cycle after the event.
  - BURST: FSM with states IDLE and BURST.
    - IDLE→BURST on a press event with i_burst ≠ 0; this loads the remaining count = i_burst and sets o_busy.
    - While in BURST, each o_tick[i_sel] emits one o_cpu_ce pulse and decrements the count.
    - The count reaches 0 → IDLE, and o_busy falls with the last pulse.
- Boundary conditions:
  - i_burst = 0 → press is ignored and o_busy stays 0.
  - Press while in BURST → ignored.
  - i_mode leaves BURST while in BURST → abort; back to IDLE next cycle, o_busy 0, no further pulses.
  - i_mode or i_sel out of range: i_sel ≥ N_CH selects channel 0.
  - i_sel change takes effect on the next cycle. Counters are free-running, so no partial or double pulse is generated.
  - RESET asserted at any time, including mid-burst: all state clears immediately (asynchronous). Counters restart from 0 on release.

## Timing
- After RESET release with i_en = 1, the first o_tick[k] occurs in cycle DIV_k (cycle 1 = first edge after release). Period is exactly DIV_k cycles.
- o_cpu_ce latency: RUN/BURST, 1 cycle after o_tick[i_sel]; STEP, 1 cycle after the press event.
- Press event latency: 2 (synchroniser) + DEB_CYCLES + 1 cycles after i_step_n settles low.
- o_busy rises 1 cycle after the press event. It falls in the same cycle as the last o_cpu_ce pulse.

## Structure
- Package clk_tick_pkg holds:
  - mode localparams: MODE_RUN = 2'd0, MODE_HALT = 2'd1, MODE_STEP = 2'd2, MODE_BURST = 2'd3;
  - FSM state encodings: IDLE, BURST;
  - default board divisor constants for 1 Hz/10 Hz/100 Hz/1 kHz.
- Sub-module button_debounce (parameter DEB_CYCLES) contains the synchroniser, the stability counter and the falling-edge event output. The top uses a generate loop for the N_CH channel counters.

## Test plan
Parameters for all scenarios: N_CH = 4, CNT_W = 8, DIVISORS ch0..ch3 = 10, 8, 6, 4, DEB_CYCLES = 4.

- Release RESET with i_en = 1 → o_tick[3] first at cycle 4, then every 4 cycles; o_sq[0] low 5 cycles / high 5 cycles, repeating.
- RUN, i_sel = 2 → o_cpu_ce pulses 1 cycle after each o_tick[2], period 6. Drop i_en for 7 cycles → no ticks; the period resumes from the held count.
- HALT for 100 cycles → o_cpu_ce stays 0 while o_tick continues. Switch to STEP, then hold i_step_n low 12 cycles preceded by a 1-0-1 bounce → exactly one o_cpu_ce pulse.
- BURST, i_sel = 3, i_burst = 3, one press → o_busy = 1; 3 o_cpu_ce pulses spaced 4 cycles apart; o_busy falls with the third pulse. A second press during the burst produces no extra pulses.
- BURST, i_burst = 5; switch to HALT after 2 pulses → o_busy = 0 next cycle, total pulses = 2. Separately, with i_burst = 0, a press → no pulses and o_busy stays 0.
- Assert RESET mid-burst → all outputs 0 asynchronously. After release, o_tick[3] first appears at cycle 4.
